axil_arbiter_2to1: RTL and testbench

Two-port AXI4-Lite arbiter that shares a single AXI4-Lite register slave (the myled register block, 4 x 32-bit registers) between two masters, e.g. the PS GP port and an on-fabric LED sequencer. Transactions from both masters are accepted one at a time, fully buffered, and forwarded with round-robin fairness. The block sits between the interconnect master ports and the myled S00_AXI port inside the block design.

---
 rtl/axil_arbiter_2to1.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_axil_arbiter_2to1.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter with round-robin fairness and one buffered
// transaction in flight. Optional response watchdog enabled by AXIL_ARB_TIMEOUT_EN.
module axil_arbiter_2to1 #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 256
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    // Master 0
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S0_AXI_AWADDR,
    input  logic [2:0]                        S0_AXI_AWPROT,
    input  logic                              S0_AXI_AWVALID,
    output logic                              S0_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S0_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S0_AXI_WSTRB,
    input  logic                              S0_AXI_WVALID,
    output logic                              S0_AXI_WREADY,
    output logic [1:0]                        S0_AXI_BRESP,
    output logic                              S0_AXI_BVALID,
    input  logic                              S0_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S0_AXI_ARADDR,
    input  logic [2:0]                        S0_AXI_ARPROT,
    input  logic                              S0_AXI_ARVALID,
    output logic                              S0_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S0_AXI_RDATA,
    output logic [1:0]                        S0_AXI_RRESP,
    output logic                              S0_AXI_RVALID,
    input  logic                              S0_AXI_RREADY,
    // Master 1
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S1_AXI_AWADDR,
    input  logic [2:0]                        S1_AXI_AWPROT,
    input  logic                              S1_AXI_AWVALID,
    output logic                              S1_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S1_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S1_AXI_WSTRB,
    input  logic                              S1_AXI_WVALID,
    output logic                              S1_AXI_WREADY,
    output logic [1:0]                        S1_AXI_BRESP,
    output logic                              S1_AXI_BVALID,
    input  logic                              S1_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S1_AXI_ARADDR,
    input  logic [2:0]                        S1_AXI_ARPROT,
    input  logic                              S1_AXI_ARVALID,
    output logic                              S1_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S1_AXI_RDATA,
    output logic [1:0]                        S1_AXI_RRESP,
    output logic                              S1_AXI_RVALID,
    input  logic                              S1_AXI_RREADY,
    // Shared slave
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StMWr, StMB, StSB, StMAr, StMR, StSR} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      prot_q, prot_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [1:0]      resp_q, resp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            tmo;

    logic [1:0]      s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
    logic [1:0]      s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
    logic [AW-1:0]   s_awaddr [2];
    logic [AW-1:0]   s_araddr [2];
    logic [2:0]      s_awprot [2];
    logic [2:0]      s_arprot [2];
    logic [DW-1:0]   s_wdata  [2];
    logic [SW-1:0]   s_wstrb  [2];
    logic [1:0]      wr_req, req;
    logic            sel;

    assign s_awvalid = {S1_AXI_AWVALID, S0_AXI_AWVALID};
    assign s_wvalid  = {S1_AXI_WVALID, S0_AXI_WVALID};
    assign s_arvalid = {S1_AXI_ARVALID, S0_AXI_ARVALID};
    assign s_bready  = {S1_AXI_BREADY, S0_AXI_BREADY};
    assign s_rready  = {S1_AXI_RREADY, S0_AXI_RREADY};
    assign s_awaddr[0] = S0_AXI_AWADDR;
    assign s_awaddr[1] = S1_AXI_AWADDR;
    assign s_araddr[0] = S0_AXI_ARADDR;
    assign s_araddr[1] = S1_AXI_ARADDR;
    assign s_awprot[0] = S0_AXI_AWPROT;
    assign s_awprot[1] = S1_AXI_AWPROT;
    assign s_arprot[0] = S0_AXI_ARPROT;
    assign s_arprot[1] = S1_AXI_ARPROT;
    assign s_wdata[0]  = S0_AXI_WDATA;
    assign s_wdata[1]  = S1_AXI_WDATA;
    assign s_wstrb[0]  = S0_AXI_WSTRB;
    assign s_wstrb[1]  = S1_AXI_WSTRB;

    // A write needs both AW and W present; reads of the same port may slip in meanwhile.
    assign wr_req = s_awvalid & s_wvalid;
    assign req    = wr_req | s_arvalid;
    assign sel    = (req[0] & req[1]) ? ~last_q : req[1];

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            in_m;

    assign in_m = (state_q == StMWr) || (state_q == StMB) || (state_q == StMAr) ||
                  (state_q == StMR);
    assign tmo  = in_m && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (in_m && !tmo) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        prot_d    = prot_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        s_awready = '0;
        s_wready  = '0;
        s_arready = '0;
        s_bvalid  = '0;
        s_rvalid  = '0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d     = sel;
                    last_d    = sel;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (wr_req[sel]) begin
                        s_awready[sel] = 1'b1;
                        s_wready[sel]  = 1'b1;
                        addr_d  = s_awaddr[sel];
                        prot_d  = s_awprot[sel];
                        wdata_d = s_wdata[sel];
                        wstrb_d = s_wstrb[sel];
                        state_d = StMWr;
                    end else begin
                        s_arready[sel] = 1'b1;
                        addr_d  = s_araddr[sel];
                        prot_d  = s_arprot[sel];
                        state_d = StMAr;
                    end
                end
            end
            StMWr: begin
                M_AXI_AWVALID = ~aw_done_q & ~tmo;
                M_AXI_WVALID  = ~w_done_q & ~tmo;
                aw_done_d = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
                w_done_d  = w_done_q | (M_AXI_WVALID & M_AXI_WREADY);
                if (aw_done_d && w_done_d) begin
                    state_d = StMB;
                end else if (tmo) begin
                    resp_d  = 2'b10;
                    state_d = StSB;
                end
            end
            StMB: begin
                M_AXI_BREADY = ~tmo;
                if (M_AXI_BVALID && !tmo) begin
                    resp_d  = M_AXI_BRESP;
                    state_d = StSB;
                end else if (tmo) begin
                    resp_d  = 2'b10;
                    state_d = StSB;
                end
            end
            StSB: begin
                s_bvalid[gnt_q] = 1'b1;
                if (s_bready[gnt_q]) begin
                    state_d = StIdle;
                end
            end
            StMAr: begin
                M_AXI_ARVALID = ~tmo;
                if (M_AXI_ARREADY && !tmo) begin
                    state_d = StMR;
                end else if (tmo) begin
                    resp_d  = 2'b10;
                    rdata_d = '0;
                    state_d = StSR;
                end
            end
            StMR: begin
                M_AXI_RREADY = ~tmo;
                if (M_AXI_RVALID && !tmo) begin
                    resp_d  = M_AXI_RRESP;
                    rdata_d = M_AXI_RDATA;
                    state_d = StSR;
                end else if (tmo) begin
                    resp_d  = 2'b10;
                    rdata_d = '0;
                    state_d = StSR;
                end
            end
            StSR: begin
                s_rvalid[gnt_q] = 1'b1;
                if (s_rready[gnt_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            prot_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            prot_q    <= prot_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = prot_q;
    assign M_AXI_ARPROT = prot_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    assign S0_AXI_AWREADY = s_awready[0];
    assign S1_AXI_AWREADY = s_awready[1];
    assign S0_AXI_WREADY  = s_wready[0];
    assign S1_AXI_WREADY  = s_wready[1];
    assign S0_AXI_ARREADY = s_arready[0];
    assign S1_AXI_ARREADY = s_arready[1];
    assign S0_AXI_BVALID  = s_bvalid[0];
    assign S1_AXI_BVALID  = s_bvalid[1];
    assign S0_AXI_RVALID  = s_rvalid[0];
    assign S1_AXI_RVALID  = s_rvalid[1];

    // Response payloads are only visible to the granted port while its response is offered.
    assign S0_AXI_BRESP = (state_q == StSB && !gnt_q) ? resp_q : 2'b00;
    assign S1_AXI_BRESP = (state_q == StSB && gnt_q) ? resp_q : 2'b00;
    assign S0_AXI_RRESP = (state_q == StSR && !gnt_q) ? resp_q : 2'b00;
    assign S1_AXI_RRESP = (state_q == StSR && gnt_q) ? resp_q : 2'b00;
    assign S0_AXI_RDATA = (state_q == StSR && !gnt_q) ? rdata_q : '0;
    assign S1_AXI_RDATA = (state_q == StSR && gnt_q) ? rdata_q : '0;

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed bench for axil_arbiter_2to1 with a small register-slave model on the M port.
// Define AXIL_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_axil_arbiter_2to1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [3:0]  awaddr [2];
    logic [3:0]  araddr [2];
    logic [2:0]  awprot [2];
    logic [2:0]  arprot [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic        awvalid [2];
    logic        wvalid  [2];
    logic        arvalid [2];
    logic        bready  [2];
    logic        rready  [2];
    logic        awready [2];
    logic        wready  [2];
    logic        arready [2];
    logic        bvalid  [2];
    logic        rvalid  [2];
    logic [1:0]  bresp   [2];
    logic [1:0]  rresp   [2];
    logic [31:0] rdata   [2];

    logic [3:0]  m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    axil_arbiter_2to1 #(
        .C_S_AXI_ADDR_WIDTH(4),
        .C_S_AXI_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S0_AXI_AWADDR(awaddr[0]), .S0_AXI_AWPROT(awprot[0]), .S0_AXI_AWVALID(awvalid[0]),
        .S0_AXI_AWREADY(awready[0]), .S0_AXI_WDATA(wdata[0]), .S0_AXI_WSTRB(wstrb[0]),
        .S0_AXI_WVALID(wvalid[0]), .S0_AXI_WREADY(wready[0]), .S0_AXI_BRESP(bresp[0]),
        .S0_AXI_BVALID(bvalid[0]), .S0_AXI_BREADY(bready[0]), .S0_AXI_ARADDR(araddr[0]),
        .S0_AXI_ARPROT(arprot[0]), .S0_AXI_ARVALID(arvalid[0]), .S0_AXI_ARREADY(arready[0]),
        .S0_AXI_RDATA(rdata[0]), .S0_AXI_RRESP(rresp[0]), .S0_AXI_RVALID(rvalid[0]),
        .S0_AXI_RREADY(rready[0]),
        .S1_AXI_AWADDR(awaddr[1]), .S1_AXI_AWPROT(awprot[1]), .S1_AXI_AWVALID(awvalid[1]),
        .S1_AXI_AWREADY(awready[1]), .S1_AXI_WDATA(wdata[1]), .S1_AXI_WSTRB(wstrb[1]),
        .S1_AXI_WVALID(wvalid[1]), .S1_AXI_WREADY(wready[1]), .S1_AXI_BRESP(bresp[1]),
        .S1_AXI_BVALID(bvalid[1]), .S1_AXI_BREADY(bready[1]), .S1_AXI_ARADDR(araddr[1]),
        .S1_AXI_ARPROT(arprot[1]), .S1_AXI_ARVALID(arvalid[1]), .S1_AXI_ARREADY(arready[1]),
        .S1_AXI_RDATA(rdata[1]), .S1_AXI_RRESP(rresp[1]), .S1_AXI_RVALID(rvalid[1]),
        .S1_AXI_RREADY(rready[1]),
        .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid),
        .M_AXI_AWREADY(m_awready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
        .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready), .M_AXI_BRESP(m_bresp),
        .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready), .M_AXI_ARADDR(m_araddr),
        .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
        .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RVALID(m_rvalid),
        .M_AXI_RREADY(m_rready)
    );

    // Slave model: 4 registers, zero-wait unless b_delay set; r_never swallows reads.
    logic [31:0] sregs [4];
    int          b_delay = 0;
    bit          r_never = 1'b0;
    int          b_cnt;
    logic        b_pend, aw_got, w_got, ar_got;
    logic [3:0]  aw_a, seen_awaddr, seen_wstrb;
    logic [2:0]  seen_awprot, seen_arprot;
    logic [31:0] w_d, seen_wdata;
    logic [3:0]  w_s;
    logic        aw_hs, w_hs, ar_hs;
    logic [3:0]  cur_a, cur_s;
    logic [31:0] cur_d;

    assign m_awready = ~aw_got & ~b_pend & ~m_bvalid;
    assign m_wready  = ~w_got & ~b_pend & ~m_bvalid;
    assign m_arready = ~ar_got & ~m_rvalid;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign ar_hs = m_arvalid & m_arready;
    assign cur_a = aw_hs ? m_awaddr : aw_a;
    assign cur_d = w_hs ? m_wdata : w_d;
    assign cur_s = w_hs ? m_wstrb : w_s;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 0; w_got <= 0; b_pend <= 0; b_cnt <= 0; ar_got <= 0;
            m_bvalid <= 0; m_bresp <= 0; m_rvalid <= 0; m_rdata <= 0; m_rresp <= 0;
            for (int i = 0; i < 4; i++) sregs[i] <= '0;
        end else begin
            if (aw_hs) begin
                aw_a <= m_awaddr; seen_awaddr <= m_awaddr; seen_awprot <= m_awprot;
            end
            if (w_hs) begin
                w_d <= m_wdata; w_s <= m_wstrb; seen_wdata <= m_wdata; seen_wstrb <= m_wstrb;
            end
            if ((aw_got | aw_hs) && (w_got | w_hs)) begin
                aw_got <= 0; w_got <= 0;
                sregs[cur_a[3:2]] <= merge(sregs[cur_a[3:2]], cur_d, cur_s);
                if (b_delay == 0) m_bvalid <= 1;
                else begin b_pend <= 1; b_cnt <= b_delay - 1; end
            end else begin
                if (aw_hs) aw_got <= 1;
                if (w_hs) w_got <= 1;
            end
            if (b_pend) begin
                if (b_cnt == 0) begin b_pend <= 0; m_bvalid <= 1; end
                else b_cnt <= b_cnt - 1;
            end
            if (m_bvalid && m_bready) m_bvalid <= 0;
            if (ar_hs) begin
                seen_arprot <= m_arprot;
                if (r_never) ar_got <= 1;
                else begin m_rvalid <= 1; m_rdata <= sregs[m_araddr[3:2]]; end
            end
            if (m_rvalid && m_rready) m_rvalid <= 0;
        end
    end

    // Grant log: port and kind of every S-side address handshake.
    int gnt_port [$];
    bit gnt_wr   [$];
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (awvalid[p] && awready[p]) begin gnt_port.push_back(p); gnt_wr.push_back(1); end
            if (arvalid[p] && arready[p]) begin gnt_port.push_back(p); gnt_wr.push_back(0); end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input int p, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int bdly, output logic [1:0] resp,
                            output int lat, output bit ok, output longint t_b);
        int n;
        ok = 1'b1; lat = 0; resp = 2'b11; t_b = 0; n = 0;
        awaddr[p] = a; awprot[p] = 3'b101; wdata[p] = d; wstrb[p] = s;
        awvalid[p] = 1'b1; wvalid[p] = 1'b1;
        do begin @(negedge clk); n++; end while (!(awready[p] && wready[p]) && n < 500);
        if (!(awready[p] && wready[p])) ok = 1'b0;
        else begin @(posedge clk); #1; end
        awvalid[p] = 1'b0; wvalid[p] = 1'b0;
        if (ok) begin
            do begin @(negedge clk); lat++; end while (!bvalid[p] && lat < 500);
            if (!bvalid[p]) ok = 1'b0;
            else begin
                for (int i = 0; i < bdly; i++) begin
                    chk("b_held", bvalid[p], 1);
                    chk("other_no_ar", arready[1-p], 0);
                    @(negedge clk);
                end
                resp = bresp[p];
                bready[p] = 1'b1;
                @(posedge clk); t_b = $time; #1;
                bready[p] = 1'b0;
            end
        end
    endtask

    task automatic do_read(input int p, input logic [3:0] a, input int maxw,
                           output logic [31:0] data, output logic [1:0] resp, output int lat,
                           output bit ok, output longint t_ar);
        int n;
        ok = 1'b1; lat = 0; resp = 2'b11; data = '1; t_ar = 0; n = 0;
        araddr[p] = a; arprot[p] = 3'b011; arvalid[p] = 1'b1;
        do begin @(negedge clk); n++; end while (!arready[p] && n < 500);
        if (!arready[p]) ok = 1'b0;
        else begin @(posedge clk); t_ar = $time; #1; end
        arvalid[p] = 1'b0;
        if (ok) begin
            do begin @(negedge clk); lat++; end while (!rvalid[p] && lat < maxw);
            if (!rvalid[p]) ok = 1'b0;
            else begin
                data = rdata[p]; resp = rresp[p];
                rready[p] = 1'b1;
                @(posedge clk); #1;
                rready[p] = 1'b0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0]  r0, r1;
    logic [31:0] d0;
    int          l0, l1, n;
    bit          ok0, ok1;
    longint      t0, t1;

    initial begin
        for (int p = 0; p < 2; p++) begin
            awaddr[p] = 0; araddr[p] = 0; awprot[p] = 0; arprot[p] = 0; wdata[p] = 0;
            wstrb[p] = 0; awvalid[p] = 0; wvalid[p] = 0; arvalid[p] = 0;
            bready[p] = 0; rready[p] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s0_awready", awready[0], 0);
        chk("rst_s1_arready", arready[1], 0);
        chk("rst_s0_bvalid", bvalid[0], 0);
        chk("rst_s1_rvalid", rvalid[1], 0);
        chk("rst_s0_rdata", rdata[0], 0);
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_bready", m_bready, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write then read on S0.
        do_write(0, 4'h4, 32'h0000_0002, 4'b0011, 0, r0, l0, ok0, t0);
        chk("wr_ok", ok0, 1);
        chk("wr_bresp", r0, 2'b00);
        chk("wr_latency", l0, 3);
        chk("m_awaddr", seen_awaddr, 4'h4);
        chk("m_wdata", seen_wdata, 32'h2);
        chk("m_awprot", seen_awprot, 3'b101);
        chk("m_wstrb", seen_wstrb, 4'b0011);
        do_read(0, 4'h4, 100, d0, r1, l1, ok1, t1);
        chk("rd_ok", ok1, 1);
        chk("rd_data", d0, 32'h2);
        chk("rd_rresp", r1, 2'b00);
        chk("rd_latency", l1, 3);
        chk("m_arprot", seen_arprot, 3'b011);

        // Both masters stream 8 writes each; grants must alternate, S1 first (S0 was last).
        gnt_port.delete(); gnt_wr.delete();
        fork
            begin
                logic [1:0] ra; int la; bit oka; longint ta;
                for (int i = 0; i < 8; i++) begin
                    do_write(0, 4'h8, 32'h10 + 32'(i), 4'hF, 0, ra, la, oka, ta);
                    chk("stream0_ok", oka, 1);
                end
            end
            begin
                logic [1:0] rb; int lb; bit okb; longint tb;
                for (int i = 0; i < 8; i++) begin
                    do_write(1, 4'hC, 32'h20 + 32'(i), 4'hF, 0, rb, lb, okb, tb);
                    chk("stream1_ok", okb, 1);
                end
            end
        join
        chk("stream_count", gnt_port.size(), 16);
        chk("stream_first", gnt_port[0], 1);
        for (int i = 1; i < 16; i++) chk("stream_alt", gnt_port[i], 1 - gnt_port[i-1]);
        chk("stream_reg2", sregs[2], 32'h17);
        chk("stream_reg3", sregs[3], 32'h27);

        // Write and read on S0 in the same cycle: write forwarded first.
        gnt_port.delete(); gnt_wr.delete();
        fork
            do_write(0, 4'h0, 32'h1, 4'hF, 0, r0, l0, ok0, t0);
            do_read(0, 4'h0, 100, d0, r1, l1, ok1, t1);
        join
        chk("wr_rd_first_is_wr", gnt_wr[0], 1);
        chk("wr_rd_second_is_rd", gnt_wr[1], 0);
        chk("wr_rd_data", d0, 32'h1);

        // Slow slave B and slow S1 BREADY; S0 read must wait for S1's B handshake.
        b_delay = 20;
        fork
            do_write(1, 4'hC, 32'h55, 4'hF, 5, r0, l0, ok0, t0);
            begin
                repeat (3) @(posedge clk);
                #1;
                do_read(0, 4'h8, 100, d0, r1, l1, ok1, t1);
            end
        join
        chk("slow_b_ok", ok0, 1);
        chk("slow_b_resp", r0, 2'b00);
        chk("slow_rd_after_b", t1 > t0, 1);
        chk("slow_rd_data", d0, 32'h17);
        b_delay = 0;

        // Reset asserted while waiting in M_B.
        b_delay = 20;
        awaddr[0] = 4'h4; wdata[0] = 32'hAA; wstrb[0] = 4'hF; awvalid[0] = 1; wvalid[0] = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_bready && n < 100);
        chk("rst_reach_mb", m_bready, 1);
        awvalid[0] = 0; wvalid[0] = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m_bready", m_bready, 0);
        chk("arst_m_awvalid", m_awvalid, 0);
        chk("arst_m_wvalid", m_wvalid, 0);
        chk("arst_s0_bvalid", bvalid[0], 0);
        chk("arst_s0_bresp", bresp[0], 0);
        b_delay = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        gnt_port.delete(); gnt_wr.delete();
        fork
            do_write(0, 4'h0, 32'h3, 4'hF, 0, r0, l0, ok0, t0);
            do_write(1, 4'h4, 32'h4, 4'hF, 0, r1, l1, ok1, t1);
        join
        chk("post_rst_ok0", ok0, 1);
        chk("post_rst_ok1", ok1, 1);
        chk("post_rst_first_s0", gnt_port[0], 0);
        chk("post_rst_then_s1", gnt_port[1], 1);

        // Slave never answers a read.
        r_never = 1'b1;
`ifdef AXIL_ARB_TIMEOUT_EN
        do_read(0, 4'h0, 100, d0, r1, l1, ok1, t1);
        chk("tmo_ok", ok1, 1);
        chk("tmo_rresp", r1, 2'b10);
        chk("tmo_rdata", d0, 32'h0);
        chk("tmo_latency", l1, 18);
        chk("tmo_no_rready", m_rready, 0);
`else
        do_read(0, 4'h0, 1000, d0, r1, l1, ok1, t1);
        chk("no_tmo_no_resp", ok1, 0);
        chk("no_tmo_rvalid", rvalid[0], 0);
        chk("no_tmo_rready_held", m_rready, 1);
`endif
        r_never = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
